// File: rtl/pipeline_fetch_queue.sv
// pipeline_fetch_queue: fetch PC, single-outstanding imem requests and a prefetch FIFO feeding decode.
// Define FETCH_BYPASS_EN to forward an ack straight to decode when the FIFO is empty.
module pipeline_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_in,
    input  logic            redirect_in,
    input  logic [PC_W-1:0] redirect_pc_in,
    output logic            imem_req_out,
    output logic [PC_W-1:0] imem_addr_out,
    input  logic            imem_ack_in,
    input  logic [15:0]     imem_rdata_in,
    output logic [15:0]     IR_out,
    output logic [PC_W-1:0] PC_out,
    output logic            valid_out,
    output logic            halt_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {FETCH, DRAIN, HALTED} state_t;
    state_t state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d, addr_q, addr_d;
    logic outstanding_q, outstanding_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [15:0] ir_q [DEPTH];
    logic [PC_W-1:0] pc_q [DEPTH];
    logic ack, bypass, pop, halting, push, issue;
    // Acks with nothing outstanding (e.g. a fetch cut off by reset) are ignored.
    assign ack = imem_ack_in && outstanding_q;
`ifdef FETCH_BYPASS_EN
    assign bypass = ack && state_q == FETCH && count_q == '0;
`else
    assign bypass = 1'b0;
`endif
    assign halt_out = state_q == HALTED;
    assign imem_req_out = outstanding_q;
    assign imem_addr_out = addr_q;
    assign valid_out = (count_q != '0 && !halt_out) || bypass;
    assign IR_out = bypass ? imem_rdata_in : valid_out ? ir_q[rd_q] : '0;
    assign PC_out = bypass ? addr_q : valid_out ? pc_q[rd_q] : '0;
    assign pop = valid_out && !stall_in && !redirect_in;
    assign halting = pop && IR_out[15:13] == 3'b111;
    assign push = ack && state_q == FETCH && !halting && !(bypass && pop);
    always_comb begin
        state_d = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d = addr_q;
        outstanding_d = outstanding_q && !ack;
        rd_d = rd_q + AW'(pop && !bypass);
        wr_d = wr_q + AW'(push);
        count_d = count_q + CW'(push) - CW'(pop && !bypass);
        // Issue against next-cycle occupancy so a retiring ack can be overlapped with the next request.
        issue = state_q == FETCH && !halting && (!outstanding_q || ack) && count_d < CW'(DEPTH);
        if (issue) begin
            outstanding_d = 1'b1;
            addr_d = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PC_W'(1);
        end
        if (state_q == DRAIN && ack)
            state_d = FETCH;
        if (halting) begin
            state_d = HALTED;
            rd_d = '0;
            wr_d = '0;
            count_d = '0;
        end
        if (redirect_in) begin
            outstanding_d = outstanding_q && !ack;
            state_d = (outstanding_q && !ack) ? DRAIN : FETCH;
            fetch_pc_d = redirect_pc_in;
            addr_d = addr_q;
            rd_d = '0;
            wr_d = '0;
            count_d = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            fetch_pc_q <= RESET_PC;
            addr_q <= RESET_PC;
            outstanding_q <= 1'b0;
            count_q <= '0;
            rd_q <= '0;
            wr_q <= '0;
        end else begin
            state_q <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q <= addr_d;
            outstanding_q <= outstanding_d;
            count_q <= count_d;
            rd_q <= rd_d;
            wr_q <= wr_d;
        end
        if (push) begin
            ir_q[wr_q] <= imem_rdata_in;
            pc_q[wr_q] <= addr_q;
        end
    end
endmodule
